// File: rtl/risky_mem_arbiter.sv
// Two-port round-robin arbiter for the shared risky memory bus with region checking and wait states.
// Optional grant/fault counters are built when RISKY_ARB_STATS_EN is defined.
module risky_mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned REGION_HI   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  output logic [31:0] rdata0,
  output logic        ack0,
  output logic        fault0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata1,
  output logic        ack1,
  output logic        fault1,
  output logic [31:0] mem_addr,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [15:0] stat_grant0,
  output logic [15:0] stat_grant1,
  output logic [15:0] stat_fault
);

  localparam logic [3:0] WAIT_L   = WAIT_CYCLES[3:0];
  localparam logic [5:0] REGION_L = REGION_HI[5:0];

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nx;
  logic        last_grant, cur, cur_we, fault_pend;
  logic [3:0]  cnt;
  logic        req_any, winner, w_we, illegal, last_cycle;
  logic [31:0] w_addr, w_wdata;

  // Contention goes to the port that did not win last; a lone requester always wins.
  assign req_any    = req0 | req1;
  assign winner     = (req0 & req1) ? ~last_grant : req1;
  assign w_addr     = winner ? addr1  : addr0;
  assign w_we       = winner ? we1    : we0;
  assign w_wdata    = winner ? wdata1 : wdata0;
  assign illegal    = (w_we && (w_addr[31:26] == 6'd0)) || (w_addr[31:26] > REGION_L);
  assign last_cycle = (cnt == WAIT_L);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_any) state_nx = illegal ? RESP : ACCESS;
      ACCESS:  if (last_cycle) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mem_oe = (state == ACCESS) && !cur_we;
    mem_we = (state == ACCESS) && cur_we && last_cycle;
    ack0   = (state == RESP) && !cur;
    ack1   = (state == RESP) && cur;
    fault0 = ack0 && fault_pend;
    fault1 = ack1 && fault_pend;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      cur        <= 1'b0;
      cur_we     <= 1'b0;
      fault_pend <= 1'b0;
      cnt        <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      case (state)
        IDLE: if (req_any) begin
          cur        <= winner;
          last_grant <= winner;
          cur_we     <= w_we;
          mem_addr   <= w_addr;
          mem_wdata  <= w_wdata;
          fault_pend <= illegal;
          cnt        <= '0;
          if (illegal) begin
            if (winner) rdata1 <= '0;
            else        rdata0 <= '0;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (last_cycle && !cur_we) begin
            if (cur) rdata1 <= mem_rdata;
            else     rdata0 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RISKY_ARB_STATS_EN
  logic [15:0] cnt_g0, cnt_g1, cnt_f;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_g0 <= '0;
      cnt_g1 <= '0;
      cnt_f  <= '0;
    end else if (ack0 || ack1) begin
      if (fault_pend) cnt_f  <= cnt_f + 16'd1;
      else if (ack0)  cnt_g0 <= cnt_g0 + 16'd1;
      else            cnt_g1 <= cnt_g1 + 16'd1;
    end
  end

  assign stat_grant0 = cnt_g0;
  assign stat_grant1 = cnt_g1;
  assign stat_fault  = cnt_f;
`else
  assign stat_grant0 = '0;
  assign stat_grant1 = '0;
  assign stat_fault  = '0;
`endif

endmodule
